// File: rtl/spi_master_sequencer.sv
// rtl/spi_master_sequencer.sv - SPI master sequencer driving an external universal shift register
//
// Purpose: drives SCLK, CS_n and the shift register mode/output-enable controls to run
// one SPI transfer per accepted i_start, then returns the received byte with a done pulse.
// The shift register's o_serial is MOSI and MISO feeds its i_serial; this block only
// sequences it.
//
// Optional feature macro: SPI_MASTER_SEQUENCER_BURST_EN
//   When defined, an i_start during END chains a further transfer with CS_n held low.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               transfer request (accepted in IDLE)
//   i_data                transmit byte, latched at accept
//   i_lsb_first/i_cpol/i_cpha  transfer mode, latched at accept
//   i_sr_parallel         shift register parallel output (received byte source)
//   o_sr_s0/o_sr_s1       shift register mode: 00 hold, 01 right, 10 left, 11 load
//   o_sr_oe0/o_sr_oe1     shift register output enables (1 = high impedance)
//   o_sr_parallel         shift register parallel load value
//   o_sclk, o_cs_n        SPI clock and active-low chip select
//   o_busy, o_done        transfer in progress, one-cycle completion pulse
//   o_rx_data             received byte, valid from o_done onward
module spi_master_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_lsb_first,
    input  logic                  i_cpol,
    input  logic                  i_cpha,
    input  logic [DATA_WIDTH-1:0] i_sr_parallel,
    output logic                  o_sr_s0,
    output logic                  o_sr_s1,
    output logic                  o_sr_oe0,
    output logic                  o_sr_oe1,
    output logic [DATA_WIDTH-1:0] o_sr_parallel,
    output logic                  o_sclk,
    output logic                  o_cs_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rx_data
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_END} state_t;

    state_t                r_state, w_state_nxt;
    logic [DIV_W-1:0]      r_div, w_div_nxt;
    logic                  r_half, w_half_nxt;
    logic [BIT_W-1:0]      r_bit, w_bit_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_lsb, w_lsb_nxt;
    logic                  r_cpol, w_cpol_nxt;
    logic                  r_cpha, w_cpha_nxt;
    logic                  w_div_last;
`ifdef SPI_MASTER_SEQUENCER_BURST_EN
    logic                  r_pend, w_pend_nxt;
`endif

    logic                  r_s0, r_s1, r_oe, r_sclk, r_cs_n, r_busy, r_done;
    logic [DATA_WIDTH-1:0] r_par, r_rx;
    logic                  w_s0, w_s1, w_oe, w_sclk, w_cs_n, w_busy, w_done;
    logic [DATA_WIDTH-1:0] w_par, w_rx;

    assign w_div_last = (r_div == DIV_LAST);

    // State, counters, latched configuration and all registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_half  <= 1'b0;
            r_bit   <= '0;
            r_data  <= '0;
            r_lsb   <= 1'b0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
`ifdef SPI_MASTER_SEQUENCER_BURST_EN
            r_pend  <= 1'b0;
`endif
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_oe    <= 1'b1;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_par   <= '0;
            r_rx    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_half  <= w_half_nxt;
            r_bit   <= w_bit_nxt;
            r_data  <= w_data_nxt;
            r_lsb   <= w_lsb_nxt;
            r_cpol  <= w_cpol_nxt;
            r_cpha  <= w_cpha_nxt;
`ifdef SPI_MASTER_SEQUENCER_BURST_EN
            r_pend  <= w_pend_nxt;
`endif
            r_s0    <= w_s0;
            r_s1    <= w_s1;
            r_oe    <= w_oe;
            r_sclk  <= w_sclk;
            r_cs_n  <= w_cs_n;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_par   <= w_par;
            r_rx    <= w_rx;
        end
    end

    // Next state and counters
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_half_nxt  = r_half;
        w_bit_nxt   = r_bit;
        w_data_nxt  = r_data;
        w_lsb_nxt   = r_lsb;
        w_cpol_nxt  = r_cpol;
        w_cpha_nxt  = r_cpha;
`ifdef SPI_MASTER_SEQUENCER_BURST_EN
        w_pend_nxt  = r_pend;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_data_nxt  = i_data;
                    w_lsb_nxt   = i_lsb_first;
                    w_cpol_nxt  = i_cpol;
                    w_cpha_nxt  = i_cpha;
                    w_div_nxt   = '0;
                    w_half_nxt  = 1'b0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_div_nxt   = '0;
                w_half_nxt  = 1'b0;
                w_bit_nxt   = '0;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_div_last) begin
                    w_div_nxt = '0;
                    if (r_half) begin
                        w_half_nxt = 1'b0;
                        if (r_bit == BIT_LAST) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = S_END;
                        end else begin
                            w_bit_nxt = r_bit + 1'b1;
                        end
                    end else begin
                        w_half_nxt = 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            S_END: begin
`ifdef SPI_MASTER_SEQUENCER_BURST_EN
                // Only new data is taken; the burst keeps the first transfer's mode.
                if (i_start) begin
                    w_data_nxt = i_data;
                    w_pend_nxt = 1'b1;
                end
`endif
                if (w_div_last) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_IDLE;
`ifdef SPI_MASTER_SEQUENCER_BURST_EN
                    if (r_pend || i_start) begin
                        w_pend_nxt  = 1'b0;
                        w_half_nxt  = 1'b0;
                        w_bit_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end
`endif
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        w_s0   = 1'b0;
        w_s1   = 1'b0;
        w_oe   = 1'b1;
        w_sclk = r_cpol;
        w_cs_n = 1'b1;
        w_busy = 1'b0;
        w_done = 1'b0;
        w_par  = r_par;
        w_rx   = r_rx;
        if (r_state == S_END && w_div_last) begin
            w_done = 1'b1;
            w_rx   = i_sr_parallel;
        end
        case (w_state_nxt)
            S_IDLE: begin
                w_sclk = i_cpol;
            end
            S_LOAD: begin
                w_s0   = 1'b1;
                w_s1   = 1'b1;
                w_par  = w_data_nxt;
                w_oe   = 1'b0;
                w_cs_n = 1'b0;
                w_busy = 1'b1;
                w_sclk = w_cpol_nxt;
            end
            S_SHIFT: begin
                w_oe   = 1'b0;
                w_cs_n = 1'b0;
                w_busy = 1'b1;
                // CPHA inverts which half of the bit period carries the active level
                w_sclk = w_cpol_nxt ^ w_half_nxt ^ w_cpha_nxt;
                if (w_half_nxt && (w_div_nxt == DIV_LAST)) begin
                    w_s0 = w_lsb_nxt;
                    w_s1 = ~w_lsb_nxt;
                end
            end
            S_END: begin
                w_oe   = 1'b0;
                w_cs_n = 1'b0;
                w_busy = 1'b1;
                w_sclk = w_cpol_nxt;
            end
            default: begin
                w_sclk = i_cpol;
            end
        endcase
    end

    assign o_sr_s0       = r_s0;
    assign o_sr_s1       = r_s1;
    assign o_sr_oe0      = r_oe;
    assign o_sr_oe1      = r_oe;
    assign o_sr_parallel = r_par;
    assign o_sclk        = r_sclk;
    assign o_cs_n        = r_cs_n;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_rx_data     = r_rx;

endmodule

// File: doc/spi_master_sequencer.md
Name: spi_master_sequencer

Overview:
- Sequences the existing 8-bit universal shift register as an SPI master transmit/receive engine.
- Generates SCLK, CS_n and the register's mode controls: load, shift-right, shift-left, hold, and output-enable.
- Sits between the host command interface and the shift register. The register's o_serial drives MOSI, and MISO drives its i_serial.
- Returns the received byte and a done pulse per transfer.

Parameters:
- CLK_DIV, 4, SCLK half-period in i_clk cycles; legal range 1..255.
- DATA_WIDTH, 8, bits per transfer; must match the shift register width.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  request a transfer; sampled only in IDLE
- i_data  in  DATA_WIDTH  transmit byte; latched when i_start is accepted
- i_lsb_first  in  1  1 = shift right (LSB first), 0 = shift left (MSB first); latched at start
- i_cpol  in  1  SCLK idle level; latched at start
- i_cpha  in  1  SCLK phase; latched at start
- i_sr_parallel  in  DATA_WIDTH  shift register o_parallel
- o_sr_s0  out  1  shift register i_s0
- o_sr_s1  out  1  shift register i_s1
- o_sr_oe0  out  1  shift register i_oe0
- o_sr_oe1  out  1  shift register i_oe1
- o_sr_parallel  out  DATA_WIDTH  shift register i_parallel
- o_sclk  out  1  SPI clock
- o_cs_n  out  1  chip select, active low
- o_busy  out  1  high from LOAD through END
- o_done  out  1  one-cycle pulse when a transfer completes
- o_rx_data  out  DATA_WIDTH  received byte; valid from o_done onward

Behaviour:
- All outputs are registered. Reset values:
  - o_sr_s0 = o_sr_s1 = 0 (hold)
  - o_sr_oe0 = o_sr_oe1 = 1 (high impedance)
  - o_sr_parallel = 0, o_sclk = 0, o_cs_n = 1, o_busy = 0, o_done = 0, o_rx_data = 0
- Reset mid-transfer: the FSM returns to IDLE at the next edge and restores the reset values. No o_done is issued.
- FSM states: IDLE -> LOAD -> SHIFT -> END -> IDLE.
- IDLE:
  - Mode = hold; OE = high-Z; o_cs_n = 1; o_sclk tracks i_cpol.
  - An i_start sampled high latches i_data, i_lsb_first, i_cpol and i_cpha, then moves to LOAD.
- LOAD (1 cycle):
  - s1s0 = 11 and o_sr_parallel = latched data.
  - o_cs_n = 0, o_busy = 1; OE = normal (oe0 = 0, oe1 = 0).
  - o_sclk = CPOL. Bit counter = 0 and divider = 0.
- SHIFT: each bit lasts 2*CLK_DIV cycles, made of a first half and a second half.
  - CPHA = 0: o_sclk = CPOL in the first half and ~CPOL in the second half.
  - CPHA = 1: o_sclk = ~CPOL in the first half and CPOL in the second half.
  - Shift pulse: in the last cycle of the second half only, drive s0 = 1, s1 = 0 if LSB-first, or s0 = 0, s1 = 1 if MSB-first. All other cycles hold (00).
  - MISO is therefore captured, and the next MOSI bit presented, at the end of each bit period.
  - After bit DATA_WIDTH-1's shift pulse, go to END.
- END (CLK_DIV cycles):
  - Mode = hold, o_sclk = CPOL, o_cs_n stays 0.
  - In the final cycle, latch o_rx_data from i_sr_parallel.
  - Next cycle: o_cs_n = 1, o_busy = 0, o_done = 1 for one cycle, OE = high-Z, state = IDLE.
- Latency: the first o_done comes 1 + 2*CLK_DIV*DATA_WIDTH + CLK_DIV + 1 cycles after the start-accept edge. For CLK_DIV = 2, DATA_WIDTH = 8 this is 36.
- i_start while o_busy is ignored, and no queueing is done.
- Back-to-back transfers: an i_start during the o_done cycle is accepted, since the FSM is already in IDLE. o_cs_n then returns low one cycle later.
- The divider counter is $clog2(CLK_DIV+1) bits wide. The bit counter is $clog2(DATA_WIDTH+1) bits wide. Both reset to 0 on every LOAD.

Optional Feature:
- Macro: SPI_MASTER_SEQUENCER_BURST_EN.
- When defined:
  - An i_start sampled high during any END cycle latches new i_data.
  - The FSM goes directly to LOAD on the cycle after END's final cycle, with o_cs_n held 0 throughout.
  - o_done still pulses for one cycle, coincident with that LOAD, and o_rx_data updates.
  - Mode settings (i_lsb_first, i_cpol, i_cpha) are not re-latched within a burst; the first transfer's values apply.
- When not defined: i_start during END is ignored, and CS_n always deasserts between transfers.

Test Plan:
- Reset: assert i_rst for 4 cycles mid-transfer (bit 3) -> the next cycle shows o_cs_n = 1, o_sclk = 0, s1s0 = 00, oe0 = oe1 = 1, o_busy = 0, and no o_done.
- MSB-first, CPOL = 0, CPHA = 0, CLK_DIV = 2, i_data = 0xA5, MISO driven with 0x3C:
  - MOSI = 1,0,1,0,0,1,0,1.
  - Exactly 8 rising SCLK edges.
  - o_rx_data = 0x3C, and o_done arrives 36 cycles after start.
- LSB-first, CPOL = 1, CPHA = 1, i_data = 0x81, MISO = 0x5A:
  - MOSI = 1,0,0,0,0,0,0,1.
  - SCLK idles high.
  - Shift pulses use s1s0 = 01.
  - o_rx_data = 0x5A.
- i_start pulsed while o_busy -> ignored. Exactly one o_done; o_rx_data equals the first transfer's MISO byte.
- Back-to-back: i_start during the o_done cycle with 0x0F, then 0xF0 -> two transfers, with o_cs_n high for exactly one cycle between them (macro not defined).
- With SPI_MASTER_SEQUENCER_BURST_EN: 3-byte burst 0x11, 0x22, 0x33 -> o_cs_n stays low throughout, three o_done pulses occur, and 24 SCLK cycles are generated.
